// File: rtl/nes_pad_poller.sv
// -----------------------------------------------------------------------------
// nes_pad_poller
//
// Autonomous poll sequencer for one NES game pad, clocked at 900 kHz.
// A poll is started either by the free-running poll timer (when enabled) or
// by a manual request. Each poll drives the pad latch for LATCH_CYC cycles,
// then produces exactly 8 pad clock pulses of HALF_CYC low / HALF_CYC high,
// sampling the (synchronized, active-low) serial data line on the last cycle
// of every low half. A one-cycle DONE state publishes the 8-bit result.
//
// Parameters
//   POLL_DIV   cycles between automatic poll triggers (> poll length + 1)
//   LATCH_CYC  cycles the latch is held high
//   HALF_CYC   cycles per pad clock half period (>= 3)
//
// Ports
//   i_clk_900KHz  system clock, all logic on its rising edge
//   i_reset       asynchronous active-high reset
//   i_enable      gates timer-driven polls (manual polls work regardless)
//   i_start_poll  manual poll request, only looked at while idle
//   i_data_in     pad serial data, active-low, asynchronous
//   o_latch       pad latch (registered)
//   o_pad_clk     pad shift clock (registered, idle low)
//   o_buttons     a,b,select,start,up,down,left,right in bits 0..7, active-high
//   o_valid       one-cycle pulse when o_buttons is updated
//   o_changed     one-cycle pulse with o_valid when the new value differs
//   o_busy        high while a poll is in progress
// -----------------------------------------------------------------------------
module nes_pad_poller #(
    parameter int POLL_DIV  = 15000,
    parameter int LATCH_CYC = 11,
    parameter int HALF_CYC  = 5
) (
    input  logic       i_clk_900KHz,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_start_poll,
    input  logic       i_data_in,
    output logic       o_latch,
    output logic       o_pad_clk,
    output logic [7:0] o_buttons,
    output logic       o_valid,
    output logic       o_changed,
    output logic       o_busy
);

    // Counter widths: the phase counter must hold the longer of the two
    // phase lengths minus one.
    localparam int TW     = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYC - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYC - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [PW-1:0] PHASE_ZERO = PW'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_phase;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_buttons;
    logic [TW-1:0]   r_timer;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_latch;
    logic            r_pad_clk;
    logic            r_valid;
    logic            r_changed;
    logic            r_busy;

    logic            w_tick;
    logic            w_trigger;

    // Timer tick only counts when automatic polling is enabled; a manual
    // request coinciding with a tick still yields a single poll.
    assign w_tick    = (r_timer == TIMER_LAST) && i_enable;
    assign w_trigger = w_tick || i_start_poll;

    assign o_latch   = r_latch;
    assign o_pad_clk = r_pad_clk;
    assign o_buttons = r_buttons;
    assign o_valid   = r_valid;
    assign o_changed = r_changed;
    assign o_busy    = r_busy;

    // Two-flop synchronizer for the pad data line; resets to the idle-high
    // level so an unplugged or idle pad reads as "no buttons pressed".
    always_ff @(posedge i_clk_900KHz or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_data_in;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running poll interval timer; keeps counting during a poll so the
    // poll rate is independent of poll duration.
    always_ff @(posedge i_clk_900KHz or posedge i_reset) begin
        if (i_reset) begin
            r_timer <= {TW{1'b0}};
        end else if (r_timer == TIMER_LAST) begin
            r_timer <= {TW{1'b0}};
        end else begin
            r_timer <= r_timer + TIMER_ONE;
        end
    end

    // Poll sequencer: state, phase/bit counters, capture register and all
    // registered pad/handshake outputs.
    always_ff @(posedge i_clk_900KHz or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_phase   <= PHASE_ZERO;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_buttons <= 8'h00;
            r_latch   <= 1'b0;
            r_pad_clk <= 1'b0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless DONE is being entered below.
            r_valid   <= 1'b0;
            r_changed <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_state <= S_LATCH;
                        r_phase <= PHASE_ZERO;
                        r_latch <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_latch   <= 1'b0;
                        r_pad_clk <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end

                S_LATCH: begin
                    if (r_phase == LATCH_LAST) begin
                        r_state <= S_LOW;
                        r_phase <= PHASE_ZERO;
                        r_bit   <= 3'd0;
                        r_latch <= 1'b0;
                    end else begin
                        r_phase <= r_phase + PHASE_ONE;
                    end
                end

                S_LOW: begin
                    // Sample on the final low cycle so the pad output has
                    // had the whole half period (minus sync delay) to settle.
                    if (r_phase == HALF_LAST) begin
                        r_shift[r_bit] <= ~r_sync2;
                        r_state        <= S_HIGH;
                        r_phase        <= PHASE_ZERO;
                        r_pad_clk      <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PHASE_ONE;
                    end
                end

                S_HIGH: begin
                    if (r_phase == HALF_LAST) begin
                        r_pad_clk <= 1'b0;
                        r_phase   <= PHASE_ZERO;
                        if (r_bit == 3'd7) begin
                            // Publish on entry to DONE so buttons, valid and
                            // changed are all visible in the DONE cycle.
                            r_state   <= S_DONE;
                            r_buttons <= r_shift;
                            r_valid   <= 1'b1;
                            r_changed <= (r_shift != r_buttons);
                        end else begin
                            r_state <= S_LOW;
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_phase <= r_phase + PHASE_ONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_phase <= PHASE_ZERO;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_phase   <= PHASE_ZERO;
                    r_latch   <= 1'b0;
                    r_pad_clk <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_pad_poller.sv
// -----------------------------------------------------------------------------
// tb_nes_pad_poller
//
// Directed bench for nes_pad_poller with POLL_DIV=200, LATCH_CYC=4,
// HALF_CYC=3 (53-cycle poll). A behavioural pad model (parallel load on
// latch, shift on pad_clk rising edge, active-low serial output) supplies
// data_in. Manual polls come from a table of {pattern, expected buttons,
// expected changed}; each one is checked cycle by cycle against the poll
// timing formulas. Automatic polling, busy collisions and reset mid-poll are
// covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_nes_pad_poller;

    localparam int P_DIV    = 200;
    localparam int P_L      = 4;
    localparam int P_H      = 3;
    localparam int POLL_LEN = P_L + 16 * P_H + 1;

    typedef struct {
        logic [7:0] pattern;
        logic [7:0] exp_buttons;
        logic       exp_changed;
    } vec_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic       start    = 1'b0;
    logic       data_in;
    logic       latch;
    logic       pclk;
    logic [7:0] buttons;
    logic       valid;
    logic       changed;
    logic       busy;

    logic [7:0] pad_pattern = 8'h00;
    logic [3:0] pad_idx     = 4'd0;

    int n_chk   = 0;
    int n_err   = 0;
    int cyc_cnt = 0;

    nes_pad_poller #(
        .POLL_DIV (P_DIV),
        .LATCH_CYC(P_L),
        .HALF_CYC (P_H)
    ) dut (
        .i_clk_900KHz(clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_start_poll(start),
        .i_data_in   (data_in),
        .o_latch     (latch),
        .o_pad_clk   (pclk),
        .o_buttons   (buttons),
        .o_valid     (valid),
        .o_changed   (changed),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Pad model: latch reloads, each pad_clk rising edge advances one bit.
    always @(posedge pclk or posedge latch) begin
        if (latch) pad_idx <= 4'd0;
        else if (pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
    end

    assign data_in = (pad_idx < 4'd8) ? ~pad_pattern[pad_idx[2:0]] : 1'b1;

    task automatic chk1(input string name, input int cyc, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk8(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Manual poll checked every cycle; j counts cycles after the accepting
    // edge t (j=1 is the first cycle after t). Call at a negedge while idle.
    task automatic run_poll(input string name, input logic [7:0] pat,
                            input logic [7:0] exp_btn, input logic exp_chg,
                            input logic [7:0] prev_btn);
        logic e_latch, e_pclk, e_busy, e_valid, e_chg;
        logic [7:0] e_btn;
        pad_pattern = pat;
        start = 1'b1;
        for (int j = 1; j <= POLL_LEN + 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 1) start = 1'b0;
            e_latch = (j <= P_L);
            e_pclk  = (j > P_L && j <= P_L + 16 * P_H) ? (((j - P_L - 1) / P_H) % 2 == 1) : 1'b0;
            e_busy  = (j <= POLL_LEN);
            e_valid = (j == POLL_LEN);
            e_chg   = (j == POLL_LEN) && exp_chg;
            e_btn   = (j >= POLL_LEN) ? exp_btn : prev_btn;
            chk1({name, "_latch"},   j, latch,   e_latch);
            chk1({name, "_pad_clk"}, j, pclk,    e_pclk);
            chk1({name, "_busy"},    j, busy,    e_busy);
            chk1({name, "_valid"},   j, valid,   e_valid);
            chk1({name, "_changed"}, j, changed, e_chg);
            chk8({name, "_buttons"}, j, buttons, e_btn);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output logic ok, output int at_cyc,
                              output logic chg, output logic [7:0] btn);
        ok = 1'b0; at_cyc = 0; chg = 1'b0; btn = 8'h00;
        for (int n = 0; n < max_cyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                ok = 1'b1; at_cyc = cyc_cnt; chg = changed; btn = buttons;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [6];
        logic [7:0] prev;
        logic       ok, g_chg, got;
        logic [7:0] g_btn;
        int         c_prev, c_now, cnt_a, cnt_b, idle_cnt;

        vecs[0] = '{pattern: 8'hA5, exp_buttons: 8'hA5, exp_changed: 1'b1};
        vecs[1] = '{pattern: 8'hA5, exp_buttons: 8'hA5, exp_changed: 1'b0};
        vecs[2] = '{pattern: 8'h5A, exp_buttons: 8'h5A, exp_changed: 1'b1};
        vecs[3] = '{pattern: 8'h00, exp_buttons: 8'h00, exp_changed: 1'b1};
        vecs[4] = '{pattern: 8'hFF, exp_buttons: 8'hFF, exp_changed: 1'b1};
        vecs[5] = '{pattern: 8'h01, exp_buttons: 8'h01, exp_changed: 1'b1};

        // Reset values, then quiet for 500 cycles with no trigger source.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_latch",   0, latch,   1'b0);
        chk1("rst_pad_clk", 0, pclk,    1'b0);
        chk1("rst_busy",    0, busy,    1'b0);
        chk1("rst_valid",   0, valid,   1'b0);
        chk1("rst_changed", 0, changed, 1'b0);
        chk8("rst_buttons", 0, buttons, 8'h00);
        rst = 1'b0;
        cnt_a = 0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (latch || pclk || busy) cnt_a++;
        end
        chki("quiet_active_cycles", cnt_a, 0);

        // Table-driven manual polls.
        prev = 8'h00;
        for (int i = 0; i < 6; i++) begin
            run_poll($sformatf("vec%0d", i), vecs[i].pattern, vecs[i].exp_buttons,
                     vecs[i].exp_changed, prev);
            prev = vecs[i].exp_buttons;
        end

        // Automatic polling: fixed period, changed only when the value moves.
        en = 1'b1;
        pad_pattern = 8'h3C;
        wait_valid(2 * P_DIV, ok, c_prev, g_chg, g_btn);
        chk1("auto0_seen",    0, ok,    1'b1);
        chk1("auto0_changed", 0, g_chg, 1'b1);
        chk8("auto0_buttons", 0, g_btn, 8'h3C);
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) pad_pattern = 8'h01;
            wait_valid(2 * P_DIV, ok, c_now, g_chg, g_btn);
            chk1($sformatf("auto%0d_seen", k),    k, ok,    1'b1);
            chki($sformatf("auto%0d_interval", k), c_now - c_prev, P_DIV);
            chk1($sformatf("auto%0d_changed", k), k, g_chg, (k == 3));
            chk8($sformatf("auto%0d_buttons", k), k, g_btn, (k >= 3) ? 8'h01 : 8'h3C);
            c_prev = c_now;
        end
        en = 1'b0;
        for (int n = 0; n < 100 && busy; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk1("auto_idle_reached", 0, busy, 1'b0);

        // Busy collision: start held through a poll gives back-to-back polls.
        pad_pattern = 8'h81;
        start = 1'b1;
        wait_valid(100, ok, c_prev, g_chg, g_btn);
        chk1("held_first_seen",    0, ok,    1'b1);
        chk1("held_first_changed", 0, g_chg, 1'b1);
        chk8("held_first_buttons", 0, g_btn, 8'h81);
        idle_cnt = 0; got = 1'b0; c_now = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!busy) idle_cnt++;
            if (valid) begin
                got = 1'b1; c_now = cyc_cnt;
                break;
            end
        end
        start = 1'b0;
        chk1("held_second_seen", 0, got, 1'b1);
        chki("held_interval", c_now - c_prev, POLL_LEN + 1);
        chki("held_idle_cycles", idle_cnt, 1);

        // A start pulse during a poll is dropped.
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        cnt_a = 0;
        for (int n = 0; n < 150; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0)  start = 1'b0;
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
            if (valid) cnt_a++;
        end
        chki("pulse_valid_count", cnt_a, 1);
        chk1("pulse_busy_end", 0, busy, 1'b0);

        // Reset during HIGH phase 3 after buttons held FF.
        run_poll("pre_ff", 8'hFF, 8'hFF, 1'b1, 8'h81);
        start = 1'b1;
        for (int j = 1; j <= P_L + 7 * P_H + 2; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 1) start = 1'b0;
        end
        chk1("rmp_pad_clk_before", 0, pclk,    1'b1);
        chk1("rmp_busy_before",    0, busy,    1'b1);
        chk8("rmp_buttons_before", 0, buttons, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk1("rmp_latch",   0, latch,   1'b0);
        chk1("rmp_pad_clk", 0, pclk,    1'b0);
        chk1("rmp_busy",    0, busy,    1'b0);
        chk1("rmp_valid",   0, valid,   1'b0);
        chk1("rmp_changed", 0, changed, 1'b0);
        chk8("rmp_buttons", 0, buttons, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) cnt_a++;
            if (busy) cnt_b++;
        end
        chki("rmp_no_valid", cnt_a, 0);
        chki("rmp_no_busy",  cnt_b, 0);
        run_poll("post_rst", 8'hFF, 8'hFF, 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
